exu_wbck: RTL



---
 rtl/exu_wbck.sv | 130 +++++++++++++
 1 files changed

// File: rtl/exu_wbck.sv
// Write-back arbiter: merges ALU and long-pipe results into one registered regfile write port.
// Latency: ALU 1 cycle to rf_wbck_o_valid; a long-pipe result passes through a 2-entry buffer, so 2 cycles minimum.
// Backpressure: ALU stalls while any long-pipe entry is buffered or the output is stalled; long-pipe stalls when the buffer is full.
module exu_wbck #(
    parameter int XLEN        = 32,
    parameter int RFIDX_W     = 5,
    parameter int LONGP_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               alu_wbck_i_valid,
    output logic               alu_wbck_i_ready,
    input  logic [XLEN-1:0]    alu_wbck_i_wdat,
    input  logic [RFIDX_W-1:0] alu_wbck_i_rdidx,
    input  logic               alu_wbck_i_rdwen,

    input  logic               longp_wbck_i_valid,
    output logic               longp_wbck_i_ready,
    input  logic [XLEN-1:0]    longp_wbck_i_wdat,
    input  logic [RFIDX_W-1:0] longp_wbck_i_rdidx,
    input  logic               longp_wbck_i_rdwen,

    output logic               rf_wbck_o_valid,
    input  logic               rf_wbck_o_ready,
    output logic [XLEN-1:0]    rf_wbck_o_wdat,
    output logic [RFIDX_W-1:0] rf_wbck_o_rdidx,
    output logic               rf_wbck_o_rdwen,

    output logic               longp_pend,
    output logic [31:0]        wbck_cnt
);

    localparam int CNT_W = $clog2(LONGP_DEPTH + 1);
    localparam int PTR_W = (LONGP_DEPTH > 1) ? $clog2(LONGP_DEPTH) : 1;

    typedef struct packed {
        logic [XLEN-1:0]    wdat;
        logic [RFIDX_W-1:0] rdidx;
        logic               rdwen;
    } wb_t;

    wb_t              buf_q [LONGP_DEPTH];
    logic [CNT_W-1:0] buf_cnt;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    wb_t              out_q;
    logic             out_vld;
    logic [31:0]      cnt_q;

    wb_t              alu_dat;
    wb_t              longp_dat;
    wb_t              sel_dat;
    logic             load_en;
    logic             buf_nonempty;
    logic             push;
    logic             pop;
    logic             load;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(LONGP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign alu_dat      = '{wdat: alu_wbck_i_wdat, rdidx: alu_wbck_i_rdidx, rdwen: alu_wbck_i_rdwen};
    assign longp_dat    = '{wdat: longp_wbck_i_wdat, rdidx: longp_wbck_i_rdidx, rdwen: longp_wbck_i_rdwen};

    assign load_en      = !out_vld || rf_wbck_o_ready;
    assign buf_nonempty = (buf_cnt != '0);

    // Buffered long-pipe results always win, so the ALU can never starve them.
    assign sel_dat      = buf_nonempty ? buf_q[rd_ptr] : alu_dat;
    assign load         = load_en && (buf_nonempty || alu_wbck_i_valid);

    assign alu_wbck_i_ready   = !buf_nonempty && load_en;
    assign longp_wbck_i_ready = (buf_cnt < CNT_W'(LONGP_DEPTH));
    assign push               = longp_wbck_i_valid && longp_wbck_i_ready;
    assign pop                = buf_nonempty && load_en;

    always_ff @(posedge clk) begin
        if (push) begin
            buf_q[wr_ptr] <= longp_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_cnt <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            out_vld <= 1'b0;
            out_q   <= '0;
            cnt_q   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                buf_cnt <= buf_cnt + CNT_W'(1);
            end else if (pop && !push) begin
                buf_cnt <= buf_cnt - CNT_W'(1);
            end

            // x0 is hardwired to zero, so its write enable is dropped here.
            if (load) begin
                out_vld     <= 1'b1;
                out_q.wdat  <= sel_dat.wdat;
                out_q.rdidx <= sel_dat.rdidx;
                out_q.rdwen <= sel_dat.rdwen && (sel_dat.rdidx != '0);
            end else if (rf_wbck_o_ready) begin
                out_vld <= 1'b0;
            end

            if (out_vld && rf_wbck_o_ready) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

    assign rf_wbck_o_valid = out_vld;
    assign rf_wbck_o_wdat  = out_q.wdat;
    assign rf_wbck_o_rdidx = out_q.rdidx;
    assign rf_wbck_o_rdwen = out_q.rdwen;
    assign longp_pend      = buf_nonempty;
    assign wbck_cnt        = cnt_q;

endmodule
